// File: rtl/bfloat16_alu.sv
// -----------------------------------------------------------------------------
// bfloat16_alu
//
// Self-contained bfloat16 arithmetic demonstrator. An internal 8-entry
// operation ROM is stepped once per clock. Each entry is {op, a, b}, and it is
// executed through a shared combinational add/sub/mul datapath. That datapath
// rounds to nearest even and flushes denormals to zero. The result is
// registered, which gives one cycle of latency from the ROM index to `result`.
//
// Ports
//   clk    : in  1  - sole clock, rising edge
//   rst_n  : in  1  - asynchronous active-low reset; clears result and index
//   result : out 16 - registered bfloat16 result of the last executed entry
//
// Opcodes: 00 a+b, 01 a-b (a + b with its sign flipped), 10 a*b,
//          11 pass a through untouched (no special-case handling).
// -----------------------------------------------------------------------------
module bfloat16_alu (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] result
);

    localparam logic [15:0] QNAN = 16'h7FC0;

    // -------------------------------------------------------------------------
    // Operand classification helpers
    // -------------------------------------------------------------------------
    function automatic logic is_nan(input logic [15:0] x);
        return (x[14:7] == 8'hFF) && (x[6:0] != 7'h00);
    endfunction

    function automatic logic is_inf(input logic [15:0] x);
        return (x[14:7] == 8'hFF) && (x[6:0] == 7'h00);
    endfunction

    // Exponent 0 covers both true zero and denormals, which are flushed.
    function automatic logic is_zero(input logic [15:0] x);
        return (x[14:7] == 8'h00);
    endfunction

    // -------------------------------------------------------------------------
    // Leading-zero count of an 11-bit value (11 when the value is zero).
    // The highest set bit is the last one seen in the loop, so it wins.
    // -------------------------------------------------------------------------
    function automatic logic [3:0] lzc11(input logic [10:0] v);
        logic [3:0] cnt;
        cnt = 4'd11;
        for (int i = 0; i <= 10; i++) begin
            if (v[i]) begin
                cnt = 4'(10 - i);
            end else begin
                cnt = cnt;
            end
        end
        return cnt;
    endfunction

    // -------------------------------------------------------------------------
    // Shared round-to-nearest-even and pack stage.
    //   mant8  : normalized significand with the hidden bit in [7]
    //   guard  : first bit below the LSB
    //   sticky : OR of everything below guard
    // The exponent is signed so that underflow (<=0) and overflow (>=255)
    // can both be detected after the rounding carry has been applied.
    // -------------------------------------------------------------------------
    function automatic logic [15:0] round_pack(
        input logic              sign,
        input logic signed [9:0] exp_in,
        input logic [7:0]        mant8,
        input logic              guard,
        input logic              sticky
    );
        logic              rnd;
        logic [8:0]        mant9;
        logic signed [9:0] exp_r;
        logic [6:0]        frac;
        logic [15:0]       res;

        rnd   = guard & (sticky | mant8[0]);
        mant9 = {1'b0, mant8} + {8'h00, rnd};
        // A carry out of the significand means 1.111..1 rounded up to 10.0.
        exp_r = exp_in + $signed({9'h000, mant9[8]});
        if (mant9[8]) begin
            frac = mant9[7:1];
        end else begin
            frac = mant9[6:0];
        end

        if (exp_r >= 10'sd255) begin
            res = {sign, 8'hFF, 7'h00};
        end else if (exp_r <= 10'sd0) begin
            res = {sign, 15'h0000};
        end else begin
            res = {sign, exp_r[7:0], frac};
        end
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Addition. Subtraction reaches here with b's sign already flipped.
    // -------------------------------------------------------------------------
    function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
        logic              swap;
        logic              s_big;
        logic              s_small;
        logic [7:0]        e_big;
        logic [7:0]        e_small;
        logic [7:0]        m_big;
        logic [7:0]        m_small;
        logic [7:0]        diff;
        logic [18:0]       shifted;
        logic [10:0]       ext_big;
        logic [10:0]       al_small;
        logic [11:0]       sum;
        logic [3:0]        lz;
        logic [10:0]       norm;
        logic signed [9:0] exp_n;
        logic [15:0]       res;

        // Order the operands by magnitude so that the subtraction below never
        // goes negative and the result sign is simply the larger one's sign.
        swap    = ({b[14:7], b[6:0]} > {a[14:7], a[6:0]});
        s_big   = swap ? b[15] : a[15];
        s_small = swap ? a[15] : b[15];
        e_big   = swap ? b[14:7] : a[14:7];
        e_small = swap ? a[14:7] : b[14:7];
        m_big   = swap ? {1'b1, b[6:0]} : {1'b1, a[6:0]};
        m_small = swap ? {1'b1, a[6:0]} : {1'b1, b[6:0]};
        diff    = e_big - e_small;

        // Working format: 8-bit significand followed by guard, round, sticky.
        ext_big = {m_big, 3'b000};
        shifted = {m_small, 11'h000} >> diff;
        if (diff >= 8'd10) begin
            // The whole operand lies below the round bit.
            al_small = 11'h001;
        end else begin
            al_small = {shifted[18:9], shifted[8] | (|shifted[7:0])};
        end

        if (s_big != s_small) begin
            sum = {1'b0, ext_big} - {1'b0, al_small};
        end else begin
            sum = {1'b0, ext_big} + {1'b0, al_small};
        end

        // Normalize so that the hidden bit sits at norm[10].
        if (sum[11]) begin
            lz    = 4'd0;
            norm  = {sum[11:2], sum[1] | sum[0]};
            exp_n = $signed({2'b00, e_big}) + 10'sd1;
        end else begin
            lz    = lzc11(sum[10:0]);
            norm  = sum[10:0] << lz;
            exp_n = $signed({2'b00, e_big}) - $signed({6'h00, lz});
        end

        if (is_nan(a) || is_nan(b)) begin
            res = QNAN;
        end else if (is_inf(a) && is_inf(b)) begin
            res = (a[15] != b[15]) ? QNAN : {a[15], 8'hFF, 7'h00};
        end else if (is_inf(a)) begin
            res = {a[15], 8'hFF, 7'h00};
        end else if (is_inf(b)) begin
            res = {b[15], 8'hFF, 7'h00};
        end else if (is_zero(a) && is_zero(b)) begin
            // Only (-0)+(-0) keeps the negative sign.
            res = {a[15] & b[15], 15'h0000};
        end else if (is_zero(a)) begin
            res = b;
        end else if (is_zero(b)) begin
            res = a;
        end else if (sum == 12'h000) begin
            // Exact cancellation is always +0.
            res = 16'h0000;
        end else begin
            res = round_pack(s_big, exp_n, norm[10:3], norm[2], norm[1] | norm[0]);
        end
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Multiplication.
    // -------------------------------------------------------------------------
    function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
        logic              sign;
        logic [15:0]       prod;
        logic signed [9:0] exp_n;
        logic [7:0]        mant8;
        logic              guard;
        logic              sticky;
        logic [15:0]       res;

        sign  = a[15] ^ b[15];
        prod  = {1'b1, a[6:0]} * {1'b1, b[6:0]};
        exp_n = $signed({2'b00, a[14:7]}) + $signed({2'b00, b[14:7]}) - 10'sd127;

        // The product of two [1,2) significands lies in [1,4): at most one
        // normalizing right shift is needed.
        if (prod[15]) begin
            mant8  = prod[15:8];
            guard  = prod[7];
            sticky = |prod[6:0];
            exp_n  = exp_n + 10'sd1;
        end else begin
            mant8  = prod[14:7];
            guard  = prod[6];
            sticky = |prod[5:0];
            exp_n  = exp_n;
        end

        if (is_nan(a) || is_nan(b)) begin
            res = QNAN;
        end else if ((is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b))) begin
            res = QNAN;
        end else if (is_inf(a) || is_inf(b)) begin
            res = {sign, 8'hFF, 7'h00};
        end else if (is_zero(a) || is_zero(b)) begin
            res = {sign, 15'h0000};
        end else begin
            res = round_pack(sign, exp_n, mant8, guard, sticky);
        end
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // State and datapath signals
    // -------------------------------------------------------------------------
    logic [2:0]  r_idx;
    logic [15:0] r_result;
    logic [1:0]  w_op;
    logic [15:0] w_a;
    logic [15:0] w_b;
    logic [15:0] w_next;

    // Fixed operation ROM addressed by the current index.
    always_comb begin
        w_op = 2'b11;
        w_a  = 16'h0000;
        w_b  = 16'h0000;
        case (r_idx)
            3'd0:    begin w_op = 2'b00; w_a = 16'h3F80; w_b = 16'h4000; end
            3'd1:    begin w_op = 2'b01; w_a = 16'h4040; w_b = 16'h3F80; end
            3'd2:    begin w_op = 2'b10; w_a = 16'h4000; w_b = 16'h4040; end
            3'd3:    begin w_op = 2'b00; w_a = 16'h3F80; w_b = 16'hBF80; end
            3'd4:    begin w_op = 2'b10; w_a = 16'h7F00; w_b = 16'h4000; end
            3'd5:    begin w_op = 2'b00; w_a = 16'h7F80; w_b = 16'hFF80; end
            3'd6:    begin w_op = 2'b00; w_a = 16'h3F80; w_b = 16'h3B80; end
            3'd7:    begin w_op = 2'b00; w_a = 16'h3F81; w_b = 16'h3B80; end
            default: begin w_op = 2'b11; w_a = 16'h0000; w_b = 16'h0000; end
        endcase
    end

    // Opcode dispatch onto the shared add/mul datapath.
    always_comb begin
        w_next = w_a;
        case (w_op)
            2'b00:   w_next = fp_add(w_a, w_b);
            2'b01:   w_next = fp_add(w_a, {~w_b[15], w_b[14:0]});
            2'b10:   w_next = fp_mul(w_a, w_b);
            2'b11:   w_next = w_a;
            default: w_next = w_a;
        endcase
    end

    // Result register and ROM sequencer; the 3-bit index wraps 7 -> 0 naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= 3'd0;
            r_result <= 16'h0000;
        end else begin
            r_idx    <= r_idx + 3'd1;
            r_result <= w_next;
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_bfloat16_alu.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_bfloat16_alu
//
// Scoreboard bench. The stimulus process owns rst_n. Before every rising edge
// on which reset is released, it computes the expected result of the ROM
// entry due at that edge. It gets that value from a real-number reference
// model and pushes it into a queue. An independent monitor samples `result`
// 1 ns after every rising edge. It pops and compares on active edges, and it
// checks for 0x0000 on edges taken while in reset. Reset lengths, run lengths
// and async assertion offsets are randomized.
// -----------------------------------------------------------------------------
module tb_bfloat16_alu;

    logic        clk;
    logic        rst_n;
    logic [15:0] result;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    int          mdl_idx = 0;

    bfloat16_alu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .result (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM contents as listed for the block: {op, a, b}
    function automatic logic [33:0] rom_entry(input int i);
        case (i)
            0: return {2'b00, 16'h3F80, 16'h4000};
            1: return {2'b01, 16'h4040, 16'h3F80};
            2: return {2'b10, 16'h4000, 16'h4040};
            3: return {2'b00, 16'h3F80, 16'hBF80};
            4: return {2'b10, 16'h7F00, 16'h4000};
            5: return {2'b00, 16'h7F80, 16'hFF80};
            6: return {2'b00, 16'h3F80, 16'h3B80};
            7: return {2'b00, 16'h3F81, 16'h3B80};
            default: return {2'b11, 16'h0000, 16'h0000};
        endcase
    endfunction

    // ---------------- reference model (double-precision arithmetic) ----------
    function automatic real bf_to_real(input logic [15:0] x);
        logic [10:0] de;
        de = {3'b000, x[14:7]} + 11'd896;
        return $bitstoreal({x[15], de, x[6:0], 45'h0});
    endfunction

    // Round a double to bfloat16 (nearest even), flush tiny, saturate to inf.
    function automatic logic [15:0] real_to_bf(input real r);
        logic [63:0] bits;
        logic [44:0] rest;
        logic [44:0] half;
        logic        s;
        int          e;
        int          m;
        bits = $realtobits(r);
        s    = bits[63];
        e    = int'(bits[62:52]) - 896;
        m    = int'(bits[51:45]);
        rest = bits[44:0];
        half = 45'd1 << 44;
        if (rest > half || (rest == half && bits[45])) m = m + 1;
        if (m == 128) begin
            m = 0;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 7'h00};
        if (e <= 0) return {s, 15'h0000};
        return {s, e[7:0], m[6:0]};
    endfunction

    function automatic logic f_nan(input logic [15:0] x);
        return x[14:7] == 8'hFF && x[6:0] != 7'h00;
    endfunction
    function automatic logic f_inf(input logic [15:0] x);
        return x[14:7] == 8'hFF && x[6:0] == 7'h00;
    endfunction
    function automatic logic f_zero(input logic [15:0] x);
        return x[14:7] == 8'h00;
    endfunction

    function automatic logic [15:0] ref_op(input logic [33:0] ent);
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        sg;
        real         r;
        op = ent[33:32];
        a  = ent[31:16];
        b  = ent[15:0];
        if (op == 2'b11) return a;
        if (op == 2'b01) b[15] = ~b[15];
        if (f_nan(a) || f_nan(b)) return 16'h7FC0;
        if (op == 2'b10) begin
            sg = a[15] ^ b[15];
            if ((f_inf(a) && f_zero(b)) || (f_zero(a) && f_inf(b))) return 16'h7FC0;
            if (f_inf(a) || f_inf(b)) return {sg, 8'hFF, 7'h00};
            if (f_zero(a) || f_zero(b)) return {sg, 15'h0000};
            r = bf_to_real(a) * bf_to_real(b);
            return real_to_bf(r);
        end
        if (f_inf(a) && f_inf(b)) return (a[15] != b[15]) ? 16'h7FC0 : a;
        if (f_inf(a)) return a;
        if (f_inf(b)) return b;
        if (f_zero(a) && f_zero(b)) return {a[15] & b[15], 15'h0000};
        if (f_zero(a)) return b;
        if (f_zero(b)) return a;
        r = bf_to_real(a) + bf_to_real(b);
        if (r == 0.0) return 16'h0000;
        return real_to_bf(r);
    endfunction

    // ---------------- checking ----------------------------------------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: result=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one sample per rising edge, 1 ns after it.
    initial begin
        logic act;
        forever begin
            @(posedge clk);
            act = rst_n;
            #1;
            if (act) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL edge_no_expect: result=%h required=<none> at %0t", result, $time);
                end else begin
                    check("edge_result", result, exp_q.pop_front());
                end
            end else begin
                check("reset_hold", result, 16'h0000);
            end
        end
    end

    // ---------------- stimulus ----------------------------------------------
    // Release (or keep released) reset for n edges, predicting each one.
    task automatic run_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            rst_n = 1'b1;
            exp_q.push_back(ref_op(rom_entry(mdl_idx)));
            mdl_idx = (mdl_idx + 1) % 8;
        end
    endtask

    // Assert reset asynchronously mid-cycle and hold it across n edges.
    task automatic reset_cycles(input int n);
        @(posedge clk);
        #($urandom_range(2, 4));
        rst_n = 1'b0;
        #1;
        check("async_reset", result, 16'h0000);
        mdl_idx = 0;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_immediate", result, 16'h0000);
        repeat (3) @(posedge clk);

        // Edges 1-5, then reset at edge 5 for two cycles, then restart.
        run_cycles(5);
        reset_cycles(2);
        // Roughly 1000 ns of free running: many wraps of the 8-entry ROM.
        run_cycles(100);

        for (int k = 0; k < 6; k++) begin
            run_cycles($urandom_range(1, 20));
            reset_cycles($urandom_range(1, 3));
        end
        run_cycles(10);

        @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: pending=%0d required=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
